// File: rtl/cbf_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cbf_packer_pkg                                            |
// | Purpose  : Shared constants, helper function and word type for the  |
// |            control-bounded-filter sample packer and its FIFO.        |
// | Ports    : none (package)                                            |
// | Options  : CBF_PACKER_LEVEL_EN (consumed by the packer and FIFO)     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cbf_packer_pkg;

  localparam int N_DEF          = 4;
  localparam int DSR_DEF        = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  // Pointer index width for the default FIFO depth (without the wrap bit).
  localparam int PTR_W = $clog2(FIFO_DEPTH_DEF);

  // Width of one down-sampled word: DSR samples of N bits each.
  function automatic int pack_width(input int n, input int dsr);
    return n * dsr;
  endfunction

  typedef logic [N_DEF*DSR_DEF-1:0] packed_word_t;

endpackage
`default_nettype wire

// File: rtl/cbf_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cbf_word_fifo                                             |
// | Purpose  : Synchronous FIFO with a registered head word. A push into |
// |            a full FIFO is accepted when a pop happens in the same    |
// |            cycle; otherwise it is refused and flagged on 'drop'.     |
// | Ports    : clk, rst       - clock, async active-high reset           |
// |            push/push_data - write request and data                   |
// |            pop_ready      - consumer ready (pop when head_valid)     |
// |            head/head_valid- registered head word and its valid       |
// |            drop           - push refused this cycle (full, no pop)   |
// |            level          - occupancy (only with CBF_PACKER_LEVEL_EN)|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cbf_word_fifo
  import cbf_packer_pkg::*;
#(
  parameter int WIDTH = pack_width(N_DEF, DSR_DEF),
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
`ifdef CBF_PACKER_LEVEL_EN
  output logic [$clog2(DEPTH):0] level,
`endif
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop     = !w_empty && pop_ready;
  assign w_push_ok = push && (!w_full || w_pop);
  assign drop      = push && !w_push_ok;

  assign w_wr_nxt = r_wr + {{AW{1'b0}}, w_push_ok};
  assign w_rd_nxt = r_rd + {{AW{1'b0}}, w_pop};

  // The head register is preloaded with whatever the read pointer will point
  // at next cycle. If that slot is the one being written right now (the FIFO
  // is, or is about to become, empty) the incoming word is forwarded into the
  // head register, giving one cycle of push-to-visible latency and no bypass.
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
    if (w_push_ok && (r_wr[AW-1:0] == w_rd_nxt[AW-1:0])) begin
      w_head_nxt = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else begin
      r_wr   <= w_wr_nxt;
      r_rd   <= w_rd_nxt;
      r_head <= w_head_nxt;
    end
  end

  assign head       = r_head;
  assign head_valid = !w_empty;

`ifdef CBF_PACKER_LEVEL_EN
  // Pointer difference is exact thanks to the wrap bit (0..DEPTH).
  assign level = r_wr - r_rd;
`endif

endmodule
`default_nettype wire

// File: rtl/cbf_sample_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cbf_sample_packer                                         |
// | Purpose  : Packs DSR consecutive N-bit control-signal samples into   |
// |            one N*DSR-bit word (oldest sample in the MSBs), buffers   |
// |            words in a FIFO and hands them out over valid/ready.      |
// |            ds_tick pulses one cycle after each word completes.       |
// | Ports    : clk, rst   - clock, async active-high reset               |
// |            in/in_valid- input sample and its qualifier               |
// |            align      - restart packing phase, drop partial word     |
// |            word_out/word_valid/word_ready - output handshake         |
// |            ds_tick    - down-sampled domain clock enable             |
// |            overflow   - sticky, a completed word was dropped         |
// |            fill_level - FIFO occupancy (CBF_PACKER_LEVEL_EN only)    |
// | Options  : `define CBF_PACKER_LEVEL_EN adds the fill_level port.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cbf_sample_packer
  import cbf_packer_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int DSR        = DSR_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           in,
  input  logic                   in_valid,
  input  logic                   align,
  output logic [N*DSR-1:0]       word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   ds_tick,
`ifdef CBF_PACKER_LEVEL_EN
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
`endif
  output logic                   overflow
);

  localparam int W       = pack_width(N, DSR);
  localparam int PHASE_W = (DSR > 1) ? $clog2(DSR) : 1;
  localparam logic [PHASE_W-1:0] C_LAST_PHASE = PHASE_W'(DSR - 1);

  logic [W-1:0]       r_shreg;
  logic [PHASE_W-1:0] r_phase;
  logic               r_ds_tick;
  logic               r_overflow;

  logic [W-1:0]       w_shifted;
  logic               w_complete;
  logic               w_drop;

  // Shift the new sample into the LSBs; with DSR=1 the sample is the word.
  generate
    if (DSR == 1) begin : g_single_sample
      assign w_shifted = in;
    end else begin : g_multi_sample
      assign w_shifted = {r_shreg[W-N-1:0], in};
    end
  endgenerate

  // align overrides a would-be completing sample: no push in that cycle.
  assign w_complete = in_valid && !align && (r_phase == C_LAST_PHASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg    <= '0;
      r_phase    <= '0;
      r_ds_tick  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ds_tick <= w_complete;
      if (align) begin
        // Partial word discarded; a sample arriving now is phase 0.
        r_phase <= (in_valid && (DSR > 1)) ? PHASE_W'(1) : '0;
        r_shreg <= in_valid ? W'(in) : '0;
      end else if (in_valid) begin
        r_phase <= (r_phase == C_LAST_PHASE) ? '0 : r_phase + 1'b1;
        r_shreg <= w_shifted;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  cbf_word_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_complete),
    .push_data  (w_shifted),
    .pop_ready  (word_ready),
    .head       (word_out),
    .head_valid (word_valid),
`ifdef CBF_PACKER_LEVEL_EN
    .level      (fill_level),
`endif
    .drop       (w_drop)
  );

  assign ds_tick  = r_ds_tick;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
